// File: rtl/sr_pulse_driver.sv
// sr_pulse_driver: turns a one-cycle request handshake into a set or reset
// pulse for a downstream SR latch. The pulse is PULSE_W cycles wide and is
// followed by GAP_W dead-time cycles. s and r are never high together.
// Build option SR_PULSE_DRIVER_FB_CHECK_EN: when defined, a CHECK state
// confirms the latch through synchronized q/qbar feedback and can raise err.
// When undefined, the request completes after the dead-time and the feedback
// inputs are ignored.
//
// state | meaning
// IDLE  | waiting for a request, req_ready=1
// PULSE | s or r held high for PULSE_W cycles
// GAP   | s=r=0 dead-time for GAP_W cycles
// CHECK | waiting up to TIMEOUT cycles for matching feedback (option only)
module sr_pulse_driver #(
    parameter int PULSE_W = 4,
    parameter int GAP_W   = 2,
    parameter int TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_level,
    output logic       s,
    output logic       r,
    input  logic       q_fb,
    input  logic       qbar_fb,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic [1:0] err_code
);
    localparam int MAX_PG  = (PULSE_W > GAP_W) ? PULSE_W : GAP_W;
    localparam int MAX_ALL = (MAX_PG > TIMEOUT) ? MAX_PG : TIMEOUT;
    localparam int CW      = $clog2(MAX_ALL + 1);
    localparam logic [CW-1:0] PULSE_LAST = CW'(PULSE_W - 1);
    localparam logic [CW-1:0] GAP_LAST   = CW'((GAP_W > 0) ? (GAP_W - 1) : 0);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PULSE = 2'd1,
        GAP   = 2'd2,
        CHECK = 2'd3
    } state_t;

    state_t          state_q;
    logic [CW-1:0]   cnt_q;
    logic [CW-1:0]   cnt_d;
    logic            s_q;
    logic            r_q;
    logic            busy_q;
    logic            done_q;

    assign cnt_d     = cnt_q + CW'(1);
    assign req_ready = (state_q == IDLE);
    assign s         = s_q;
    assign r         = r_q;
    assign busy      = busy_q;
    assign done      = done_q;

`ifdef SR_PULSE_DRIVER_FB_CHECK_EN
    localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);

    logic       level_q;
    logic       err_q;
    logic [1:0] err_code_q;
    logic       q_s1_q, q_s2_q;
    logic       qbar_s1_q, qbar_s2_q;
    logic       fb_match;

    assign err      = err_q;
    assign err_code = err_code_q;
    assign fb_match = (q_s2_q == level_q) && (qbar_s2_q == ~level_q);

    // two-flop synchronizer for the asynchronous latch feedback
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_s1_q    <= 1'b0;
            q_s2_q    <= 1'b0;
            qbar_s1_q <= 1'b0;
            qbar_s2_q <= 1'b0;
        end else begin
            q_s1_q    <= q_fb;
            q_s2_q    <= q_s1_q;
            qbar_s1_q <= qbar_fb;
            qbar_s2_q <= qbar_s1_q;
        end
    end
`else
    logic unused_fb;

    assign unused_fb = q_fb ^ qbar_fb;
    assign err       = 1'b0;
    assign err_code  = 2'b00;
`endif

    // sequencing FSM with registered drive and status outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            s_q        <= 1'b0;
            r_q        <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
`ifdef SR_PULSE_DRIVER_FB_CHECK_EN
            level_q    <= 1'b0;
            err_q      <= 1'b0;
            err_code_q <= 2'b00;
`endif
        end else begin
            done_q <= 1'b0;
`ifdef SR_PULSE_DRIVER_FB_CHECK_EN
            err_q      <= 1'b0;
            err_code_q <= 2'b00;
`endif
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        state_q <= PULSE;
                        cnt_q   <= '0;
                        s_q     <= req_level;
                        r_q     <= ~req_level;
                        busy_q  <= 1'b1;
`ifdef SR_PULSE_DRIVER_FB_CHECK_EN
                        level_q <= req_level;
`endif
                    end
                end
                PULSE: begin
                    if (cnt_q == PULSE_LAST) begin
                        cnt_q <= '0;
                        s_q   <= 1'b0;
                        r_q   <= 1'b0;
                        if (GAP_W > 0) begin
                            state_q <= GAP;
                        end else begin
`ifdef SR_PULSE_DRIVER_FB_CHECK_EN
                            state_q <= CHECK;
`else
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
`endif
                        end
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                GAP: begin
                    if (cnt_q == GAP_LAST) begin
                        cnt_q <= '0;
`ifdef SR_PULSE_DRIVER_FB_CHECK_EN
                        state_q <= CHECK;
`else
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
`endif
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
`ifdef SR_PULSE_DRIVER_FB_CHECK_EN
                CHECK: begin
                    if (fb_match) begin
                        state_q <= IDLE;
                        cnt_q   <= '0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else if (cnt_q == TO_LAST) begin
                        state_q    <= IDLE;
                        cnt_q      <= '0;
                        busy_q     <= 1'b0;
                        err_q      <= 1'b1;
                        // both rails equal means the latch is invalid, not just wrong
                        err_code_q <= (q_s2_q == qbar_s2_q) ? 2'b10 : 2'b01;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
`endif
                default: begin
                    state_q <= IDLE;
                    cnt_q   <= '0;
                    s_q     <= 1'b0;
                    r_q     <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sr_pulse_driver.sv
// Scoreboard bench for sr_pulse_driver: a behavioural SR latch closes the
// feedback loop, each accepted request pushes its expected completion, and a
// negedge monitor pops and compares when done/err appears. A second instance
// with PULSE_W=1, GAP_W=0 covers the shortest configuration.
module tb_sr_pulse_driver;
    localparam int PW = 4;
    localparam int GW = 2;
    localparam int TO = 16;
`ifdef SR_PULSE_DRIVER_FB_CHECK_EN
    localparam bit FB_EN   = 1'b1;
    localparam int LAT     = PW + GW + 1;
    localparam int ERR_LAT = PW + GW + TO;
    // single-cycle pulse: the 2-flop synchronizer makes the new level visible
    // at the third edge after accept, so confirmation lands there
    localparam int LAT1    = 3;
`else
    localparam bit FB_EN   = 1'b0;
    localparam int LAT     = PW + GW;
    localparam int ERR_LAT = PW + GW;
    localparam int LAT1    = 1;
`endif

    typedef struct {
        int       cyc;
        bit       is_err;
        bit [1:0] code;
        bit       lvl;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic req_valid = 1'b0, req_level = 1'b0;
    logic req_ready, s, r, busy, done, err;
    logic [1:0] err_code;
    logic q_fb, qbar_fb;
    logic lq = 1'b0;
    int   fb_mode = 0;

    logic req_valid1 = 1'b0;
    logic req_ready1, s1, r1, busy1, done1, err1;
    logic [1:0] err_code1;
    logic lq1 = 1'b0;

    int   cyc = 0;
    int   n_checks = 0;
    int   n_errors = 0;
    int   s_hi = 0, r_hi = 0;
    exp_t sb[$];

    sr_pulse_driver #(.PULSE_W(PW), .GAP_W(GW), .TIMEOUT(TO)) u_dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_level(req_level), .s(s), .r(r), .q_fb(q_fb), .qbar_fb(qbar_fb),
        .busy(busy), .done(done), .err(err), .err_code(err_code)
    );

    sr_pulse_driver #(.PULSE_W(1), .GAP_W(0), .TIMEOUT(TO)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid1), .req_ready(req_ready1),
        .req_level(1'b1), .s(s1), .r(r1), .q_fb(lq1), .qbar_fb(~lq1),
        .busy(busy1), .done(done1), .err(err1), .err_code(err_code1)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // behavioural SR latches driven by each instance
    always @(s or r) begin
        if (s && !r) lq = 1'b1;
        else if (r && !s) lq = 1'b0;
    end
    always @(s1 or r1) begin
        if (s1 && !r1) lq1 = 1'b1;
        else if (r1 && !s1) lq1 = 1'b0;
    end

    assign q_fb    = (fb_mode == 0) ? lq  : (fb_mode == 1) ? 1'b0 : 1'b1;
    assign qbar_fb = (fb_mode == 0) ? ~lq : 1'b1;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    // invariants every cycle, plus scoreboard compare on completion
    always @(negedge clk) begin
        exp_t e;
        chk("s_r_excl", 32'(s & r), 0);
        chk("done_err_excl", 32'(done & err), 0);
        chk("busy_vs_ready", 32'(busy), 32'(!req_ready));
        chk("s1_r1_excl", 32'(s1 & r1), 0);
        chk("err1_never", 32'(err1), 0);
        if (s) s_hi++;
        if (r) r_hi++;
        if (done || err) begin
            if (sb.size() == 0) begin
                chk("spurious_out", 1, 0);
            end else begin
                e = sb.pop_front();
                chk("out_cycle", cyc, e.cyc);
                chk("done", 32'(done), 32'(!e.is_err));
                chk("err", 32'(err), 32'(e.is_err));
                chk("err_code", 32'(err_code), e.is_err ? 32'(e.code) : 0);
                chk("latch_q", 32'(lq), 32'(e.lvl));
                chk("s_width", s_hi, e.lvl ? PW : 0);
                chk("r_width", r_hi, e.lvl ? 0 : PW);
            end
            s_hi = 0;
            r_hi = 0;
        end
    end

    task automatic wait_ready();
        int n = 0;
        while (!req_ready && n < 60) begin
            @(negedge clk);
            n++;
        end
        chk("ready_timeout", 32'(req_ready), 1);
    endtask

    task automatic send(input bit lvl, input bit is_err, input bit [1:0] code);
        exp_t e;
        @(negedge clk);
        wait_ready();
        req_valid = 1'b1;
        req_level = lvl;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        e.cyc = cyc + (is_err ? ERR_LAT : LAT);
        e.is_err = is_err;
        e.code = code;
        e.lvl = lvl;
        sb.push_back(e);
    endtask

    task automatic wait_drain(input int bound);
        int n = 0;
        while (sb.size() != 0 && n < bound) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        chk("drain_timeout", sb.size(), 0);
    endtask

    initial begin
        exp_t e;
        int acc;
        repeat (3) @(negedge clk);
        chk("rst_ready", 32'(req_ready), 1);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_s", 32'(s), 0);
        chk("rst_r", 32'(r), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_err", 32'(err), 0);
        chk("rst_code", 32'(err_code), 0);
        rst_n = 1'b1;

        // set request
        send(1'b1, 1'b0, 2'b00);
        wait_drain(40);

        // reset request with req_valid held through busy; it must be taken
        // only at the edge closing the done cycle
        @(negedge clk);
        wait_ready();
        req_valid = 1'b1;
        req_level = 1'b0;
        @(posedge clk);
        #1;
        acc = cyc;
        e.cyc = acc + LAT; e.is_err = 1'b0; e.code = 2'b00; e.lvl = 1'b0;
        sb.push_back(e);
        req_level = 1'b1;
        for (int k = 0; k < LAT; k++) begin
            @(negedge clk);
            chk("held_busy", 32'(busy), 1);
        end
        @(negedge clk);
        chk("held_done_cycle_idle", 32'(busy), 0);
        @(posedge clk);
        #1;
        chk("held_accepted", 32'(busy), 1);
        req_valid = 1'b0;
        e.cyc = cyc + LAT; e.is_err = 1'b0; e.code = 2'b00; e.lvl = 1'b1;
        sb.push_back(e);
        wait_drain(40);

        // same level again is still pulsed
        send(1'b1, 1'b0, 2'b00);
        wait_drain(40);

        // stuck feedback q=0/qbar=1 while setting
        fb_mode = 1;
        send(1'b1, FB_EN, 2'b01);
        wait_drain(60);

        // invalid feedback q=qbar=1 while resetting
        fb_mode = 2;
        send(1'b0, FB_EN, 2'b10);
        wait_drain(60);
        fb_mode = 0;

        // shortest configuration on the second instance
        @(negedge clk);
        req_valid1 = 1'b1;
        @(posedge clk);
        #1;
        req_valid1 = 1'b0;
        for (int k = 0; k <= LAT1 + 1; k++) begin
            if (k > 0) begin
                @(posedge clk);
                #1;
            end
            chk("d1_s", 32'(s1), 32'(k == 0));
            chk("d1_r", 32'(r1), 0);
            chk("d1_done", 32'(done1), 32'(k == LAT1));
            chk("d1_busy", 32'(busy1), 32'(k < LAT1));
        end
        chk("d1_latch_q", 32'(lq1), 1);

        // reset in the middle of a pulse
        send(1'b0, 1'b0, 2'b00);
        @(negedge clk);
        chk("pre_rst_r_high", 32'(r), 1);
        #2;
        rst_n = 1'b0;
        sb.delete();
        #1;
        chk("abort_s", 32'(s), 0);
        chk("abort_r", 32'(r), 0);
        chk("abort_ready", 32'(req_ready), 1);
        chk("abort_busy", 32'(busy), 0);
        repeat (2) @(negedge clk);
        s_hi = 0;
        r_hi = 0;
        rst_n = 1'b1;
        repeat (30) @(negedge clk);
        chk("post_abort_idle", 32'(busy), 0);

        // recovery after abort
        send(1'b1, 1'b0, 2'b00);
        wait_drain(40);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

// File: doc/sr_pulse_driver.md
Name: sr_pulse_driver

Overview:
Drives the set/reset inputs of a downstream SR latch (q/qbar storage element) from a single-cycle request handshake. It converts each request into a mutually exclusive, fixed-width set or reset pulse, followed by a dead-time gap. It then confirms the latch state through its q/qbar feedback. It sits between control logic and any SR latch instance, and it guarantees that the latch never sees s=r=1.

Parameters:
PULSE_W, 4, cycles s or r is held high per request (legal: >=1)
GAP_W, 2, dead-time cycles with s=r=0 after the pulse (legal: >=0)
TIMEOUT, 16, maximum CHECK cycles to wait for matching feedback (legal: >=1)

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
req_valid  input  1  request present
req_ready  output  1  driver can accept a request
req_level  input  1  target latch value: 1 = set, 0 = reset
s  output  1  latch set drive
r  output  1  latch reset drive
q_fb  input  1  latch q feedback, asynchronous
qbar_fb  input  1  latch qbar feedback, asynchronous
busy  output  1  request in progress
done  output  1  one-cycle pulse: request completed and confirmed
err  output  1  one-cycle pulse: confirmation timed out
err_code  output  2  valid with err: 01 = wrong level, 10 = q==qbar (invalid/both)

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-low (rst_n).
- All outputs are registered except req_ready, which equals (state==IDLE).
- Reset values: state IDLE, s=0, r=0, busy=0, done=0, err=0, err_code=00, all counters 0, feedback synchronizers 0. req_ready=1 while in reset.
- Reset mid-operation drops s and r immediately (asynchronously). No done or err is produced for the aborted request.
- Handshake: a request is accepted on a clk edge where req_valid & req_ready are both 1. req_level is captured at that edge. While busy, req_valid is ignored and not queued.
- FSM states: IDLE, PULSE, GAP, CHECK.
  - IDLE -> PULSE on accept. busy=1 from the accept edge.
  - PULSE lasts exactly PULSE_W cycles. s=captured level and r=~captured level are registered, so they are high from the accept edge. Then -> GAP, or -> CHECK if GAP_W=0.
  - GAP lasts GAP_W cycles with s=r=0. Then -> CHECK.
  - CHECK evaluates the synchronized feedback every cycle, for at most TIMEOUT cycles.
    - Match (q_fb==level and qbar_fb==~level): -> IDLE with done=1 for one cycle.
    - No match after TIMEOUT cycles: -> IDLE with err=1. err_code=10 if the last sampled q_fb==qbar_fb, else 01.
- q_fb and qbar_fb pass through a 2-flop synchronizer before use.
- Invariants:
  - s and r are never both 1.
  - done and err are never both 1.
  - busy is 0 exactly when state is IDLE.
- Latency with defaults and settled feedback: done is high 7 cycles after the accept edge (PULSE_W+GAP_W+1). The worst-case err is 22 cycles after accept (PULSE_W+GAP_W+TIMEOUT).
- done and err assert in the first IDLE cycle. A new request can be accepted in that same cycle.
- A request for a level the latch already holds is still pulsed and checked; no skip.
- Counter widths are $clog2 of max(PULSE_W, GAP_W, TIMEOUT)+1. Counters reset to 0 on every state entry, so there is no wrap.

Optional Feature:
Macro: SR_PULSE_DRIVER_FB_CHECK_EN
- Defined: the CHECK state, feedback synchronizer, err and err_code are implemented as described above.
- Undefined: CHECK is removed and q_fb/qbar_fb are ignored.
  - GAP -> IDLE with done=1, or PULSE -> IDLE if GAP_W=0.
  - err and err_code are tied to 0.
  - done is high PULSE_W+GAP_W cycles after accept (6 with defaults).

Test Plan:
- Reset: assert rst_n=0 mid-PULSE -> s=r=0 immediately; req_ready=1, busy=0, no done/err after release.
- Set request: defaults, behavioural SR latch model on s/r/q/qbar, req_level=1 -> s high 4 cycles, r stays 0, 2 gap cycles, done high exactly 7 cycles after accept, latch q=1.
- Reset request: after the set request, req_level=0 -> r high 4 cycles, done at +7, latch q=0. A req_valid held during busy is not accepted; it is accepted in the cycle done=1.
- Stuck feedback: tie q_fb=0, qbar_fb=1, req_level=1 -> err=1 with err_code=01 at +22, no done.
- Invalid feedback: tie q_fb=qbar_fb=1 -> err=1 with err_code=10 at +22. Assert s&r==0 every cycle throughout.
- Macro undefined, GAP_W=0, PULSE_W=1: req_level=1 -> s high 1 cycle, done at +1; err never asserts.
